// File: rtl/mu_feeder.sv
// mu_feeder: holds one kernel plus bias, streams weight/data pairs into MU, and returns MU's result on valid/ready.
// Optional WAIT watchdog enabled by defining MU_FEEDER_TIMEOUT_EN (adds TIMEOUT parameter and timeout_err port).
module mu_feeder #(
  parameter int WIDTH       = 8,
  parameter int kernel_size = 3
`ifdef MU_FEEDER_TIMEOUT_EN
  , parameter int TIMEOUT   = 64
`endif
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   wload_valid,
  input  logic [WIDTH-1:0]                       wload_data,
  output logic                                   wload_ready,
  input  logic                                   bias_load,
  input  logic [WIDTH-1:0]                       bias_in,
  input  logic                                   win_valid,
  input  logic [kernel_size*kernel_size*WIDTH-1:0] win_data,
  output logic                                   win_ready,
  output logic                                   weight_valid,
  output logic                                   data_valid,
  output logic [WIDTH-1:0]                       weight,
  output logic [WIDTH-1:0]                       data,
  output logic [WIDTH-1:0]                       bias,
  input  logic [WIDTH-1:0]                       conv_result,
  input  logic                                   conv_result_valid,
  output logic                                   out_valid,
  output logic [WIDTH-1:0]                       out_data,
  input  logic                                   out_ready,
  output logic                                   busy
`ifdef MU_FEEDER_TIMEOUT_EN
  , output logic                                 timeout_err
`endif
);

  localparam int N  = kernel_size * kernel_size;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
`ifdef MU_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       weights_q [N];
  logic [WIDTH-1:0]       weights_d [N];
  logic [IW-1:0]          widx_q, widx_d;
  logic                   loaded_q, loaded_d;
  logic [N*WIDTH-1:0]     window_q, window_d;
  logic [IW-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]       bias_q, bias_d;
  logic [WIDTH-1:0]       weight_q, weight_d;
  logic [WIDTH-1:0]       data_q, data_d;
  logic                   vld_q, vld_d;
  logic                   out_valid_q, out_valid_d;
  logic [WIDTH-1:0]       out_data_q, out_data_d;
  logic                   wload_ready_q, wload_ready_d;
  logic                   win_ready_q, win_ready_d;
  logic                   busy_q, busy_d;
`ifdef MU_FEEDER_TIMEOUT_EN
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   terr_q, terr_d;
`endif

  logic wload_fire_s;
  logic win_fire_s;

  assign wload_fire_s = wload_valid && wload_ready_q;
  assign win_fire_s   = win_valid && win_ready_q;

  // Next-state, storage updates, and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    weights_d   = weights_q;
    widx_d      = widx_q;
    loaded_d    = loaded_q;
    window_d    = window_q;
    cnt_d       = cnt_q;
    bias_d      = bias_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
`ifdef MU_FEEDER_TIMEOUT_EN
    tmo_d       = tmo_q;
    terr_d      = terr_q;
`endif

    if (bias_load) begin
      bias_d = bias_in;
    end else begin
      bias_d = bias_q;
    end

    if (wload_fire_s) begin
      weights_d[widx_q] = wload_data;
      if (widx_q == IW'(N - 1)) begin
        widx_d   = '0;
        loaded_d = 1'b1;
      end else begin
        widx_d   = widx_q + IW'(1);
      end
    end else begin
      widx_d = widx_q;
    end

    case (state_q)
      IDLE: begin
        if (win_fire_s) begin
          window_d = win_data;
          cnt_d    = '0;
          state_d  = ISSUE;
        end else begin
          state_d  = IDLE;
        end
      end
      ISSUE: begin
        if (cnt_q == IW'(N - 1)) begin
          state_d = WAIT;
`ifdef MU_FEEDER_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end else begin
          cnt_d   = cnt_q + IW'(1);
        end
      end
      WAIT: begin
        if (conv_result_valid) begin
          out_data_d  = conv_result;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
`ifdef MU_FEEDER_TIMEOUT_EN
          // MU silent too long: release the pipeline with a zero result.
          if (tmo_q == TW'(TIMEOUT - 1)) begin
            terr_d      = 1'b1;
            out_data_d  = '0;
            out_valid_d = 1'b1;
            state_d     = HOLD;
          end else begin
            tmo_d       = tmo_q + TW'(1);
          end
`else
          state_d = WAIT;
`endif
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d     = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    wload_ready_d = (state_d == IDLE);
    win_ready_d   = (state_d == IDLE) && loaded_d;
    busy_d        = (state_d == ISSUE) || (state_d == WAIT);
    vld_d         = (state_d == ISSUE);
    // Look up from the post-write arrays so a same-cycle weight write is what MU sees.
    if (state_d == ISSUE) begin
      weight_d = weights_d[cnt_d];
      data_d   = window_d[32'(cnt_d) * WIDTH +: WIDTH];
    end else begin
      weight_d = '0;
      data_d   = '0;
    end
  end

  // State, storage and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      for (int i = 0; i < N; i++) begin
        weights_q[i] <= '0;
      end
      widx_q        <= '0;
      loaded_q      <= 1'b0;
      window_q      <= '0;
      cnt_q         <= '0;
      bias_q        <= '0;
      weight_q      <= '0;
      data_q        <= '0;
      vld_q         <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      wload_ready_q <= 1'b0;
      win_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
`ifdef MU_FEEDER_TIMEOUT_EN
      tmo_q         <= '0;
      terr_q        <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      weights_q     <= weights_d;
      widx_q        <= widx_d;
      loaded_q      <= loaded_d;
      window_q      <= window_d;
      cnt_q         <= cnt_d;
      bias_q        <= bias_d;
      weight_q      <= weight_d;
      data_q        <= data_d;
      vld_q         <= vld_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      wload_ready_q <= wload_ready_d;
      win_ready_q   <= win_ready_d;
      busy_q        <= busy_d;
`ifdef MU_FEEDER_TIMEOUT_EN
      tmo_q         <= tmo_d;
      terr_q        <= terr_d;
`endif
    end
  end

  assign wload_ready  = wload_ready_q;
  assign win_ready    = win_ready_q;
  assign weight_valid = vld_q;
  assign data_valid   = vld_q;
  assign weight       = weight_q;
  assign data         = data_q;
  assign bias         = bias_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign busy         = busy_q;
`ifdef MU_FEEDER_TIMEOUT_EN
  assign timeout_err  = terr_q;
`endif

endmodule
